// File: rtl/mdu_if.sv
// Handshake and result bundle between the execute stage and the HI/LO
// multiply/divide sequencer.
//   valid   : execute stage presents an RTYPE funct this cycle
//   funct   : funct field of the presented instruction
//   a, b    : rs / rt operands
//   stall   : freeze the pipeline this cycle
//   busy    : multiply/divide in flight
//   hi, lo  : architectural HI/LO registers
//   mf_data : MFHI/MFLO read data
interface mdu_if #(
   parameter int WIDTH = 32
);
   logic             valid;
   logic [5:0]       funct;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             stall;
   logic             busy;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] mf_data;

   modport master (
      output valid, funct, a, b,
      input  stall, busy, hi, lo, mf_data
   );

   modport slave (
      input  valid, funct, a, b,
      output stall, busy, hi, lo, mf_data
   );
endinterface

// File: rtl/mdu_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// One radix-2 step per cycle on operand magnitudes, sign fixup on exit.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : mdu_if slave (valid/funct/a/b in; stall/busy/hi/lo/mf_data out)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | accept MT/MF and start mult/div commands
// CALC  | WIDTH shift-add (mult) or restoring shift-subtract (div) steps
// FIN   | sign fixup, HI/LO written on the edge leaving this state
module mdu_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
   mdu_if.slave bus
);
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic               op_div;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic               mdu_cmd;
   logic               op_cmd;
   logic               in_signed;
   logic               in_neg_a;
   logic               in_neg_b;
   logic [WIDTH-1:0]   in_mag_a;
   logic [WIDTH-1:0]   in_mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH-1:0]   a_orig;

   always_comb begin
      mdu_cmd   = 1'b0;
      op_cmd    = 1'b0;
      in_signed = 1'b0;
      if (bus.valid) begin
         mdu_cmd = (bus.funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                      F_MULT, F_MULTU, F_DIV, F_DIVU});
         op_cmd  = (bus.funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
      end
      in_signed = (bus.funct == F_MULT) || (bus.funct == F_DIV);
      in_neg_a  = in_signed && bus.a[WIDTH-1];
      in_neg_b  = in_signed && bus.b[WIDTH-1];
      in_mag_a  = in_neg_a ? -bus.a : bus.a;
      in_mag_b  = in_neg_b ? -bus.b : bus.b;

      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
      // Partial remainder shifted left with the next dividend bit; the
      // remainder is always below the divisor, so WIDTH+1 bits suffice.
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_shift - {1'b0, mag_b};

      prod_fix  = (sign_a ^ sign_b) ? -acc : acc;
      quo_fix   = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix   = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      // Raw dividend bits for the divide-by-zero result.
      a_orig    = sign_a ? -mag_a : mag_a;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         op_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         acc    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (op_cmd) begin
                  op_div <= bus.funct[1];
                  sign_a <= in_neg_a;
                  sign_b <= in_neg_b;
                  mag_a  <= in_mag_a;
                  mag_b  <= in_mag_b;
                  // Multiplier or dividend sits in the low half of acc.
                  acc    <= {{WIDTH{1'b0}}, bus.funct[1] ? in_mag_a : in_mag_b};
                  cnt    <= '0;
                  state  <= CALC;
               end else if (bus.valid && bus.funct == F_MTHI) begin
                  hi_q <= bus.a;
               end else if (bus.valid && bus.funct == F_MTLO) begin
                  lo_q <= bus.a;
               end
            end
            CALC: begin
               if (op_div) begin
                  if (!div_diff[WIDTH])
                     acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                  else
                     acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
               end else begin
                  if (acc[0])
                     acc <= {mul_sum, acc[WIDTH-1:1]};
                  else
                     acc <= {1'b0, acc[2*WIDTH-1:1]};
               end
               cnt <= cnt + 1'b1;
               if (cnt == LAST)
                  state <= FIN;
            end
            FIN: begin
               if (!op_div) begin
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end else if (mag_b == '0) begin
                  hi_q <= a_orig;
                  lo_q <= '1;
               end else begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy    = (state != IDLE);
   assign bus.stall   = mdu_cmd && (state != IDLE);
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
   assign bus.mf_data = (bus.funct == F_MFHI) ? hi_q : lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;
   localparam logic [5:0] F_ADD   = 6'h20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   mdu_if #(.WIDTH(32)) bus();

   mdu_ctrl #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] f,
                        input logic [31:0] aa, input logic [31:0] bb);
      bus.valid = v;
      bus.funct = f;
      bus.a     = aa;
      bus.b     = bb;
      #1;
   endtask

   task automatic issue(input logic [5:0] f, input logic [31:0] aa, input logic [31:0] bb);
      drive(1'b1, f, aa, bb);
      tick();
      drive(1'b0, 6'h00, 32'h0, 32'h0);
   endtask

   task automatic run_to_idle(output int n);
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin
         n++;
         tick();
      end
   endtask

   task automatic test_reset();
      drive(1'b0, 6'h00, 32'h0, 32'h0);
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
      n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
      n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
   endtask

   task automatic test_multu();
      int n;
      issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_to_idle(n);
      n_cmp++; if (n !== 33) begin n_err++; $display("FAIL multu_busy_cycles got=%0d exp=33", n); end
      n_cmp++; if (bus.hi !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_hi got=%h exp=fffffffe", bus.hi); end
      n_cmp++; if (bus.lo !== 32'h00000001) begin n_err++; $display("FAIL multu_lo got=%h exp=00000001", bus.lo); end
   endtask

   task automatic test_signed();
      int n;
      issue(F_MULT, 32'hFFFFFFFD, 32'd5);
      run_to_idle(n);
      n_cmp++; if (bus.hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", bus.hi); end
      n_cmp++; if (bus.lo !== 32'hFFFFFFF1) begin n_err++; $display("FAIL mult_neg_lo got=%h exp=fffffff1", bus.lo); end
      issue(F_DIV, 32'hFFFFFFF9, 32'd2);
      run_to_idle(n);
      n_cmp++; if (n !== 33) begin n_err++; $display("FAIL div_busy_cycles got=%0d exp=33", n); end
      n_cmp++; if (bus.lo !== 32'hFFFFFFFD) begin n_err++; $display("FAIL div_neg_lo got=%h exp=fffffffd", bus.lo); end
      n_cmp++; if (bus.hi !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_neg_hi got=%h exp=ffffffff", bus.hi); end
      issue(F_DIVU, 32'd100, 32'd7);
      run_to_idle(n);
      n_cmp++; if (bus.lo !== 32'd14) begin n_err++; $display("FAIL divu_lo got=%h exp=0000000e", bus.lo); end
      n_cmp++; if (bus.hi !== 32'd2) begin n_err++; $display("FAIL divu_hi got=%h exp=00000002", bus.hi); end
   endtask

   task automatic test_div_boundary();
      int n;
      issue(F_DIVU, 32'h12345678, 32'h0);
      run_to_idle(n);
      n_cmp++; if (bus.lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL divu_zero_lo got=%h exp=ffffffff", bus.lo); end
      n_cmp++; if (bus.hi !== 32'h12345678) begin n_err++; $display("FAIL divu_zero_hi got=%h exp=12345678", bus.hi); end
      issue(F_DIV, 32'hFFFFFFFB, 32'h0);
      run_to_idle(n);
      n_cmp++; if (bus.lo !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_zero_lo got=%h exp=ffffffff", bus.lo); end
      n_cmp++; if (bus.hi !== 32'hFFFFFFFB) begin n_err++; $display("FAIL div_zero_hi got=%h exp=fffffffb", bus.hi); end
      issue(F_DIV, 32'h80000000, 32'hFFFFFFFF);
      run_to_idle(n);
      n_cmp++; if (bus.lo !== 32'h80000000) begin n_err++; $display("FAIL div_wrap_lo got=%h exp=80000000", bus.lo); end
      n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL div_wrap_hi got=%h exp=00000000", bus.hi); end
   endtask

   task automatic test_mt_mf();
      issue(F_MTHI, 32'hCAFEF00D, 32'h0);
      drive(1'b1, F_MFHI, 32'h0, 32'h0);
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL mfhi_stall got=%b exp=0", bus.stall); end
      n_cmp++; if (bus.mf_data !== 32'hCAFEF00D) begin n_err++; $display("FAIL mfhi_data got=%h exp=cafef00d", bus.mf_data); end
      tick();
      issue(F_MTLO, 32'd7, 32'h0);
      n_cmp++; if (bus.lo !== 32'd7) begin n_err++; $display("FAIL mtlo_lo got=%h exp=00000007", bus.lo); end
      drive(1'b1, F_MFLO, 32'h0, 32'h0);
      n_cmp++; if (bus.mf_data !== 32'd7) begin n_err++; $display("FAIL mflo_data got=%h exp=00000007", bus.mf_data); end
      n_cmp++; if (bus.hi !== 32'hCAFEF00D) begin n_err++; $display("FAIL mtlo_keeps_hi got=%h exp=cafef00d", bus.hi); end
      drive(1'b0, 6'h00, 32'h0, 32'h0);
   endtask

   task automatic test_reset_abort();
      int n;
      issue(F_DIVU, 32'd100, 32'd7);
      repeat (9) tick();
      n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_before got=%b exp=1", bus.busy); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
      n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL abort_hi got=%h exp=00000000", bus.hi); end
      n_cmp++; if (bus.lo !== 32'h0) begin n_err++; $display("FAIL abort_lo got=%h exp=00000000", bus.lo); end
      issue(F_MULTU, 32'd6, 32'd7);
      run_to_idle(n);
      n_cmp++; if (n !== 33) begin n_err++; $display("FAIL abort_multu_cycles got=%0d exp=33", n); end
      n_cmp++; if (bus.lo !== 32'd42) begin n_err++; $display("FAIL abort_multu_lo got=%h exp=0000002a", bus.lo); end
      n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL abort_multu_hi got=%h exp=00000000", bus.hi); end
   endtask

   task automatic test_stall();
      int n;
      int bad_stall;
      issue(F_MTHI, 32'h11111111, 32'h0);
      issue(F_MULT, 32'd3, 32'd4);
      drive(1'b1, F_MFLO, 32'h0, 32'h0);
      bad_stall = 0;
      for (int c = 1; c <= 33; c++) begin
         if (bus.stall !== 1'b1) bad_stall++;
         if (c == 10) begin
            n_cmp++; if (bus.hi !== 32'h11111111) begin n_err++; $display("FAIL hold_hi_calc got=%h exp=11111111", bus.hi); end
         end
         tick();
      end
      n_cmp++; if (bad_stall !== 0) begin n_err++; $display("FAIL stall_cycles_1_33 got=%0d low cycles exp=0", bad_stall); end
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL stall_cycle34 got=%b exp=0", bus.stall); end
      n_cmp++; if (bus.mf_data !== 32'd12) begin n_err++; $display("FAIL mflo_after_mult got=%h exp=0000000c", bus.mf_data); end
      drive(1'b0, 6'h00, 32'h0, 32'h0);

      issue(F_MULTU, 32'd2, 32'd3);
      repeat (3) tick();
      drive(1'b1, F_ADD, 32'h0, 32'h0);
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL non_mdu_stall got=%b exp=0", bus.stall); end
      drive(1'b1, F_MTHI, 32'hDEADBEEF, 32'h0);
      n_cmp++; if (bus.stall !== 1'b1) begin n_err++; $display("FAIL mthi_busy_stall got=%b exp=1", bus.stall); end
      tick();
      drive(1'b0, 6'h00, 32'h0, 32'h0);
      n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL mthi_busy_hi got=%h exp=00000000", bus.hi); end
      run_to_idle(n);
      n_cmp++; if (bus.lo !== 32'd6) begin n_err++; $display("FAIL multu_small_lo got=%h exp=00000006", bus.lo); end
      n_cmp++; if (bus.hi !== 32'h0) begin n_err++; $display("FAIL multu_small_hi got=%h exp=00000000", bus.hi); end
   endtask

   task automatic test_ignore();
      drive(1'b1, F_ADD, 32'd5, 32'd5);
      n_cmp++; if (bus.stall !== 1'b0) begin n_err++; $display("FAIL ignore_idle_stall got=%b exp=0", bus.stall); end
      tick();
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ignore_funct_busy got=%b exp=0", bus.busy); end
      drive(1'b0, F_MULT, 32'd5, 32'd5);
      tick();
      drive(1'b0, F_MTLO, 32'h55555555, 32'd0);
      tick();
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ignore_invalid_busy got=%b exp=0", bus.busy); end
      n_cmp++; if (bus.lo !== 32'd6) begin n_err++; $display("FAIL ignore_invalid_lo got=%h exp=00000006", bus.lo); end
      drive(1'b0, 6'h00, 32'h0, 32'h0);
   endtask

   initial begin
      bus.valid = 1'b0;
      bus.funct = 6'h00;
      bus.a     = 32'h0;
      bus.b     = 32'h0;
      test_reset();
      test_multu();
      test_signed();
      test_div_boundary();
      test_mt_mf();
      test_reset_abort();
      test_stall();
      test_ignore();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Iterative multiply/divide sequencer for the MIPS datapath.
- Owns the HI/LO architectural registers.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles using a shared radix-2 add/subtract-shift engine.
- Services MFHI/MFLO/MTHI/MTLO, and raises a stall to the pipeline whenever an HI/LO-class instruction arrives while an operation is in flight.
- Sits beside the ALU in the execute stage and is selected when opcode is RTYPE with one of the funct codes below.

Parameters:
- WIDTH, 32, operand/register width. Iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid  input  1  execute stage holds an RTYPE instruction whose funct is presented this cycle.
- funct  input  6  funct field: MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13, MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B. Any other value is ignored.
- a  input  WIDTH  rs operand (multiplicand/dividend; MT source).
- b  input  WIDTH  rt operand (multiplier/divisor).
- stall  output  1  freeze the pipeline this cycle.
- busy  output  1  operation in flight.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- mf_data  output  WIDTH  MFHI → hi, MFLO → lo; otherwise lo.

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE; hi=0, lo=0, all internal accumulators 0.
  - Any in-flight operation is discarded.
  - Outputs after reset: busy=0, stall=0.
- State machine IDLE → CALC → FIN → IDLE.
- Definitions:
  - mdu_cmd = valid && funct ∈ {MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU}.
  - stall = mdu_cmd && (state != IDLE). Combinational, no dependence on rst.
  - busy = (state != IDLE).
- IDLE behaviour for each command:
  - MULT/MULTU/DIV/DIVU: latch operands at the edge. Signed ops latch magnitudes plus the two sign bits. Clear the iteration counter; go to CALC.
  - MTHI: hi ← a at the edge. MTLO: lo ← a at the edge. No stall.
  - MFHI/MFLO: mf_data is combinational from the current hi/lo, so the result is valid in the same cycle. No state change.
- CALC:
  - Exactly WIDTH cycles; counter counts 0..WIDTH-1, then go to FIN.
  - Multiply: shift-add on the unsigned magnitudes; the 2*WIDTH-bit product is accumulated.
  - Divide: restoring shift-subtract on the unsigned magnitudes; produces quotient and remainder.
- FIN (1 cycle): apply sign fixup and write hi/lo at the edge leaving FIN; go to IDLE.
  - MULT: negate the 2*WIDTH-bit product if the operand signs differ. hi = product[2W-1:W], lo = product[W-1:0].
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign. lo = quotient, hi = remainder.
  - Unsigned ops: no fixup.
- Latency:
  - Command accepted at edge E0.
  - busy high for cycles 1..WIDTH+1 (33 cycles at WIDTH=32).
  - hi/lo updated at edge E(WIDTH+1). A dependent MF in cycle WIDTH+2 reads the new value.
- Boundary cases:
  - Divide by zero (b=0, any signedness): lo = all ones, hi = a (original, unsigned-interpreted bits). No exception.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (natural two's-complement wrap).
  - Stalled command while busy: not accepted. The same instruction is re-presented by the pipeline and accepted in the first IDLE cycle. MT during busy does not write.
  - hi/lo hold their values throughout CALC/FIN until the FIN edge.
  - rst asserted during CALC/FIN: immediate abort per reset rules. Pending hi/lo write is lost.
  - valid low or non-MDU funct: no effect in any state.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → busy 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD(-3) b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=-7 b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x12345678 b=0 → lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MULT issued, then MFLO held valid from cycle 1 → stall=1 in cycles 1..33, stall=0 in cycle 34 with mf_data = new lo. MTHI during busy leaves hi unchanged.
- MTHI a=0xCAFEF00D then MFHI the next cycle → stall=0, mf_data=0xCAFEF00D. MTLO a=7 → lo=7.
- DIVU started, rst pulsed in cycle 10 → next cycle busy=0, hi=lo=0. A new MULTU 6*7 then completes with lo=42, hi=0.
